// File: rtl/reg_dump.sv
// Register-file readout engine: walks every register address and streams (addr, data) beats.
// Optional trailing checksum beat enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump #(
  parameter int REG_SIZE   = 32,
  parameter int NO_OF_REGS = 32,
  parameter int REGW       = $clog2(NO_OF_REGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic [REGW-1:0]     raddr_o,
  input  logic [REG_SIZE-1:0] rdata_i,
  output logic                dump_valid_o,
  input  logic                dump_ready_i,
  output logic [REGW-1:0]     dump_addr_o,
  output logic [REG_SIZE-1:0] dump_data_o,
  output logic                dump_last_o,
  output logic                busy_o,
  output logic                done_o
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

  localparam logic [REGW-1:0] LAST_ADDR = REGW'(NO_OF_REGS - 1);

  state_t          state;
  logic [REGW-1:0] addr;
  logic            hs;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [REG_SIZE-1:0] csum;
`endif

  assign raddr_o = addr;
  assign hs      = dump_valid_o && dump_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr         <= '0;
      dump_valid_o <= 1'b0;
      dump_addr_o  <= '0;
      dump_data_o  <= '0;
      dump_last_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            addr   <= '0;
            busy_o <= 1'b1;
            state  <= LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
            csum   <= '0;
`endif
          end
        end
        LOAD: begin
          // rdata_i is sampled only here; later register-file writes cannot disturb the beat
          dump_data_o  <= rdata_i;
          dump_addr_o  <= addr;
          dump_valid_o <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
          dump_last_o  <= 1'b0;
`else
          dump_last_o  <= (addr == LAST_ADDR);
`endif
          state        <= SEND;
        end
        SEND: begin
          if (hs) begin
            dump_valid_o <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum         <= csum + dump_data_o;
`endif
            if (addr == LAST_ADDR) begin
              dump_last_o <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
              state       <= CSUM;
`else
              done_o      <= 1'b1;
              state       <= DONE;
`endif
            end else begin
              addr  <= addr + 1'b1;
              state <= LOAD;
            end
          end
        end
`ifdef REG_DUMP_CHECKSUM_EN
        CSUM: begin
          // First cycle loads the checksum beat, then it is held until accepted
          if (!dump_valid_o) begin
            dump_valid_o <= 1'b1;
            dump_addr_o  <= '0;
            dump_data_o  <= csum;
            dump_last_o  <= 1'b1;
          end else if (dump_ready_i) begin
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            done_o       <= 1'b1;
            state        <= DONE;
          end
        end
`endif
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: register-file model, random ready, reference beats queued per dump.
module tb_reg_dump;
  localparam int N    = 32;
  localparam int RS   = 32;
  localparam int AW   = 5;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, ready;
  logic [AW-1:0] raddr, daddr;
  logic [RS-1:0] rdata, ddata;
  logic          dvalid, dlast, busy, done;

  logic [RS-1:0] regs [N];

  typedef struct {
    logic [AW-1:0] addr;
    logic [RS-1:0] data;
    logic          last;
  } beat_t;
  beat_t q[$];

  int vectors = 0;
  int errors  = 0;
  int mode    = 0;
  int bp      = 0;
  bit scramble = 1'b0;

  reg_dump #(.REG_SIZE(RS), .NO_OF_REGS(N), .REGW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .raddr_o(raddr), .rdata_i(rdata),
    .dump_valid_o(dvalid), .dump_ready_i(ready), .dump_addr_o(daddr),
    .dump_data_o(ddata), .dump_last_o(dlast), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  assign rdata = regs[raddr];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Ready driver: 0 = always high, 1 = random, 2 = five-cycle stall on beat 7
  always @(posedge clk) begin
    #1;
    case (mode)
      1: ready = ($urandom_range(0, 3) != 0);
      2: if (dvalid && daddr == 5'd7 && bp < 5) begin ready = 1'b0; bp++; end
         else ready = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // Overwrite the register being presented; the in-flight beat must keep the old value
  always @(negedge clk)
    if (scramble && !rst && dvalid) regs[raddr] = $urandom;

  // Monitor
  bit            exp_done = 1'b0;
  bit            stall = 1'b0;
  logic [AW-1:0] s_addr;
  logic [RS-1:0] s_data;
  logic          s_last;
  always @(negedge clk) begin
    if (rst) begin
      exp_done = 1'b0;
      stall    = 1'b0;
    end else begin
      if (done || exp_done) chk("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 1'b0;
      if (stall) begin
        chk("hold_valid", 64'(dvalid), 64'd1);
        chk("hold_beat", {daddr, ddata, dlast}, {s_addr, s_data, s_last});
      end
      if (dvalid && ready) begin
        if (q.size() == 0) begin
          vectors++; errors++;
          $display("FAIL extra_beat: got addr %0d data %0h expected no beat", daddr, ddata);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_addr", 64'(daddr), 64'(e.addr));
          chk("beat_data", 64'(ddata), 64'(e.data));
          chk("beat_last", 64'(dlast), 64'(e.last));
          exp_done = e.last;
        end
      end
      stall  = dvalid && !ready;
      s_addr = daddr; s_data = ddata; s_last = dlast;
    end
  end

  task automatic push_expected();
    logic [RS-1:0] sum;
    beat_t b;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      b.addr = AW'(i); b.data = regs[i]; b.last = (i == N - 1) && !CSUM_ON;
      q.push_back(b);
      sum += regs[i];
    end
    if (CSUM_ON) begin
      b.addr = '0; b.data = sum; b.last = 1'b1;
      q.push_back(b);
    end
  endtask

  task automatic issue_start();
    push_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_dump(input int m, input bit timed, input bit extra);
    int cnt;
    bit got;
    mode = m; bp = 0;
    issue_start();
    cnt = 0; got = 1'b0;
    while (!got && cnt < 3000) begin
      @(negedge clk); cnt++;
      if (cnt == 1) chk("busy_rise", 64'(busy), 64'd1);
      if (extra && cnt == 9)  start = 1'b1;
      if (extra && cnt == 10) start = 1'b0;
      if (done) got = 1'b1;
    end
    if (!got) begin
      vectors++; errors++;
      $display("FAIL done_timeout: got no done_o expected done_o within 3000 cycles");
    end
    if (timed) chk("dump_cycles", 64'(cnt), 64'(2 * N + 1 + (CSUM_ON ? 2 : 0)));
    if (extra) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    @(negedge clk);
    chk("busy_fall", 64'(busy), 64'd0);
    if (extra) begin
      repeat (3) @(negedge clk);
      chk("no_restart", 64'(busy), 64'd0);
    end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [63:0] outs();
    return 64'({raddr, dvalid, daddr, ddata, dlast, busy, done});
  endfunction

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    for (int i = 0; i < N; i++) regs[i] = RS'(i * 32'h11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("reset_outputs", outs(), 64'd0);
    end

    run_dump(0, 1'b1, 1'b0);           // basic preload, full-rate timing
    run_dump(2, 1'b0, 1'b0);           // backpressure on beat 7
    chk("stall_cycles", 64'(bp), 64'd5);

    scramble = 1'b1;
    repeat (4) begin
      for (int i = 1; i < N; i++) regs[i] = $urandom;
      regs[0] = '0;
      run_dump(1, 1'b0, 1'b0);
    end
    scramble = 1'b0;

    // Reset during SEND of beat 12
    mode = 0;
    issue_start();
    cnt = 0;
    while (!(dvalid && daddr == 5'd12) && cnt < 500) begin
      @(posedge clk); #2; cnt++;
    end
    if (cnt >= 500) begin
      vectors++; errors++;
      $display("FAIL beat12_timeout: got no beat 12 expected beat 12 within 500 cycles");
    end
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midreset_outputs", outs(), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midreset_quiet", outs(), 64'd0);
    end

    run_dump(0, 1'b1, 1'b0);           // fresh start from addr 0
    run_dump(1, 1'b0, 1'b1);           // starts while busy and in the done cycle

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
